mips_dmem_bridge: RTL and testbench

MIPS_DMEM_BRIDGE -- requirements
Module: mips_dmem_bridge

---
 rtl/mips_dmem_bridge.sv | 109 ++++++++++
 tb/tb_mips_dmem_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_bridge.sv
// Data-memory bridge between a single-cycle MIPS core and a ready/req bus.
// Stalls the core while a bus access is outstanding; flags misalignment and timeouts.
module mips_dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DATA_MEM_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_re,
  input  logic                      mem_we,
  input  logic [DATA_MEM_WIDTH-1:0] addr,
  input  logic [DATA_MEM_WIDTH-1:0] wdata,
  output logic [DATA_MEM_WIDTH-1:0] rdata,
  output logic                      stall,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [DATA_MEM_WIDTH-1:0] bus_addr,
  output logic [DATA_MEM_WIDTH-1:0] bus_wdata,
  input  logic                      bus_ready,
  input  logic [DATA_MEM_WIDTH-1:0] bus_rdata,
  output logic                      err_timeout,
  output logic                      err_misalign,
  output logic [15:0]               access_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] tmo_cnt_q;
  logic       request;
  logic       misalign;
  logic       tmo_hit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign request  = mem_re | mem_we;
  assign misalign = |addr[1:0];
  // A completion on the last permitted cycle takes priority over the timeout.
  assign tmo_hit  = (state_q == BUSY) && !bus_ready && (tmo_cnt_q == TMO_LAST);
  assign stall    = ((state_q == IDLE) && request) || (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (request) state_d = misalign ? DONE : BUSY;
      BUSY:    if (bus_ready || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tmo_cnt_q    <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      rdata        <= '0;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
      access_cnt   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (request) begin
            if (misalign) begin
              err_misalign <= 1'b1;
              rdata        <= '0;
            end else begin
              // Store wins when both strobes are high: bus_we follows mem_we alone.
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= addr;
              bus_wdata <= wdata;
              tmo_cnt_q <= '0;
            end
          end
        end
        BUSY: begin
          if (bus_ready) begin
            bus_req    <= 1'b0;
            rdata      <= bus_we ? '0 : bus_rdata;
            access_cnt <= sat_inc16(access_cnt);
          end else if (tmo_hit) begin
            bus_req     <= 1'b0;
            err_timeout <= 1'b1;
            rdata       <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Bench for mips_dmem_bridge: directed scenarios followed by randomized accesses,
// each checked against a transaction-level model of the bridge.
module tb_mips_dmem_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_re, mem_we;
  logic [31:0] addr, wdata, rdata;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ready;
  logic        err_timeout, err_misalign;
  logic [15:0] access_cnt;

  int tests = 0;
  int fails = 0;

  // Transaction-level model state
  logic [31:0] m_rdata;
  logic [15:0] m_cnt;
  logic        m_tmo, m_mis;

  mips_dmem_bridge #(.TIMEOUT_CYCLES(TMO), .DATA_MEM_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_re(mem_re), .mem_we(mem_we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .err_timeout(err_timeout), .err_misalign(err_misalign),
    .access_cnt(access_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_rdata"}, rdata, m_rdata);
    check({tag, "_cnt"}, {16'd0, access_cnt}, {16'd0, m_cnt});
    check({tag, "_etmo"}, {31'd0, err_timeout}, {31'd0, m_tmo});
    check({tag, "_emis"}, {31'd0, err_misalign}, {31'd0, m_mis});
  endtask

  // One core access, entered and left at a falling edge with the bridge idle.
  // delay = index of the BUSY cycle carrying bus_ready; delay >= TMO means never.
  task automatic access(input bit re, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int delay);
    bit req;
    bit wr;
    req = re | we;
    wr  = we;
    mem_re = re; mem_we = we; addr = a; wdata = wd; bus_ready = 1'b0;
    #1;
    check("idle_stall", {31'd0, stall}, {31'd0, req});
    check("idle_req", {31'd0, bus_req}, 32'd0);
    if (!req) begin
      @(negedge clk);
      return;
    end
    if (a[1:0] != 2'b00) begin
      m_mis = 1'b1;
      m_rdata = 32'd0;
    end else begin
      for (int c = 0; c < TMO; c++) begin
        @(negedge clk);
        #1;
        check("busy_req", {31'd0, bus_req}, 32'd1);
        check("busy_stall", {31'd0, stall}, 32'd1);
        check("busy_addr", bus_addr, a);
        check("busy_wdata", bus_wdata, wd);
        check("busy_we", {31'd0, bus_we}, {31'd0, wr});
        check("busy_rdata_hold", rdata, m_rdata);
        mem_re = 1'($urandom); mem_we = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        if (c == delay) begin
          bus_ready = 1'b1;
          bus_rdata = rd;
          m_rdata = wr ? 32'd0 : rd;
          m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
          break;
        end
        bus_rdata = $urandom;
        if (c == TMO - 1) begin
          m_tmo = 1'b1;
          m_rdata = 32'd0;
        end
      end
    end
    @(negedge clk);
    // DONE: a request and a stray bus_ready here must both be ignored
    mem_re = 1'($urandom); mem_we = 1'($urandom);
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    #1;
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_req", {31'd0, bus_req}, 32'd0);
    check_status("done");
    @(negedge clk);
    bus_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_re = 1'b0; mem_we = 1'b0; addr = '0; wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    m_rdata = '0; m_cnt = '0; m_tmo = 1'b0; m_mis = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall_idle", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_we", {31'd0, bus_we}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check_status("rst");
    mem_re = 1'b1;
    #1;
    check("rst_stall_req", {31'd0, stall}, 32'd1);
    @(negedge clk);
    mem_re = 1'b0;
    rst_n = 1'b1;

    // Load with two BUSY cycles, store ready at once, timeout, misalign, read+write
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 1);
    access(1'b0, 1'b1, 32'h20, 32'h12345678, 32'hFFFFFFFF, 0);
    access(1'b1, 1'b0, 32'h30, 32'h0, 32'h0, TMO);
    access(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 0);
    access(1'b1, 1'b0, 32'h44, 32'h0, 32'hA5A5A5A5, TMO - 1);
    access(1'b1, 1'b1, 32'h48, 32'h87654321, 32'h5A5A5A5A, 2);
    access(1'b0, 1'b0, 32'h4C, 32'h0, 32'h0, 0);

    // Reset during the second BUSY cycle, then a late bus_ready
    mem_re = 1'b1; mem_we = 1'b0; addr = 32'h50; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_rdata = '0; m_cnt = '0; m_tmo = 1'b0; m_mis = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, bus_req}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd1);
    check("mid_rst_addr", bus_addr, 32'd0);
    check_status("mid_rst");
    rst_n = 1'b1; mem_re = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    check("post_rst_req", {31'd0, bus_req}, 32'd0);
    check("post_rst_stall", {31'd0, stall}, 32'd0);
    check_status("post_rst");
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      access(op[0], op[1], a, $urandom, $urandom, int'($urandom_range(0, TMO)));
    end

    // Counter saturation, starting just below the limit
    force dut.access_cnt = 16'hFFFE;
    #1;
    release dut.access_cnt;
    m_cnt = 16'hFFFE;
    access(1'b1, 1'b0, 32'h100, 32'h0, 32'h11111111, 0);
    access(1'b0, 1'b1, 32'h104, 32'h22222222, 32'h0, 1);
    access(1'b1, 1'b0, 32'h108, 32'h0, 32'h33333333, 0);
    check("sat_final", {16'd0, access_cnt}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
